// File: rtl/note_tone_gen.sv
// Square-wave note synthesiser: increment table, 24-bit NCO, ATTACK/SUSTAIN/RELEASE envelope.
// Latency: one clock from sample_tick_in to sample_valid_out. There is no backpressure; note events are never buffered.
module note_tone_gen #(
    parameter int PHASE_W      = 24,
    parameter int SAMPLE_W     = 16,
    parameter int F_SAMPLE     = 48000,
    parameter int AMP          = 8192,
    parameter int ATTACK_STEP  = 32,
    parameter int RELEASE_STEP = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [5:0]          note_in,
    input  logic                note_valid_in,
    input  logic                sample_tick_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid_out,
    output logic                note_active_out,
    output logic [4:0]          cur_note_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ATTACK  = 2'd1,
        S_SUSTAIN = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam int NUM_NOTES = 22;
    localparam int PROD_W    = SAMPLE_W + 9;
    localparam logic signed [SAMPLE_W-1:0] AMP_S = SAMPLE_W'(AMP);

    // Table is padded to 32 entries so any 5-bit note code indexes safely.
    logic [PHASE_W-1:0] inc_tab [32];

    for (genvar g = 0; g < 32; g++) begin : g_inc
        if (g < NUM_NOTES) begin : g_note
            localparam real FREQ  = 261.6256 * (2.0 ** (g / 12.0));
            localparam real INC_R = FREQ * (2.0 ** PHASE_W) / F_SAMPLE;
            localparam logic [PHASE_W-1:0] INC = PHASE_W'($rtoi(INC_R + 0.5));
            assign inc_tab[g] = INC;
        end else begin : g_pad
            assign inc_tab[g] = '0;
        end
    end

    state_t                      state_q, state_d;
    logic [7:0]                  env_q, env_d;
    logic [PHASE_W-1:0]          phase_q, phase_d;
    logic [PHASE_W-1:0]          inc_q, inc_d;
    logic [4:0]                  cur_note_q, cur_note_d;
    logic signed [SAMPLE_W-1:0]  sample_q, sample_d;
    logic                        sample_vld_q, sample_vld_d;
    logic                        note_active_q, note_active_d;

    logic                        note_on;
    logic                        note_off;
    logic signed [SAMPLE_W-1:0]  amp_s;
    logic signed [PROD_W-1:0]    amp_ext;
    logic signed [PROD_W-1:0]    env_ext;
    logic signed [PROD_W-1:0]    prod;
    logic signed [PROD_W-1:0]    prod_sh;
    logic [8:0]                  env_sum;

    always_comb begin
        note_on  = note_valid_in && note_in[5] && (note_in[4:0] <= 5'd21);
        note_off = note_valid_in && !note_on;

        amp_s   = phase_q[PHASE_W-1] ? -AMP_S : AMP_S;
        amp_ext = PROD_W'(amp_s);
        env_ext = $signed({{(PROD_W-8){1'b0}}, env_q});
        prod    = amp_ext * env_ext;
        prod_sh = prod >>> 8;
        env_sum = {1'b0, env_q} + 9'(ATTACK_STEP);

        state_d      = state_q;
        env_d        = env_q;
        phase_d      = phase_q;
        inc_d        = inc_q;
        cur_note_d   = cur_note_q;
        sample_d     = sample_q;
        sample_vld_d = sample_tick_in;

        if (sample_tick_in) begin
            sample_d = prod_sh[SAMPLE_W-1:0];
            if (state_q != S_IDLE) begin
                phase_d = phase_q + inc_q;
            end
        end

        // A note event owns the state and increment; the tick's envelope step is dropped.
        if (note_on) begin
            state_d    = S_ATTACK;
            inc_d      = inc_tab[note_in[4:0]];
            cur_note_d = note_in[4:0];
            if (state_q == S_IDLE) begin
                phase_d = '0;
                env_d   = 8'd0;
            end
        end else if (note_off && (state_q != S_IDLE)) begin
            state_d = S_RELEASE;
        end else if (sample_tick_in) begin
            case (state_q)
                S_ATTACK: begin
                    if (env_sum >= 9'd255) begin
                        env_d   = 8'd255;
                        state_d = S_SUSTAIN;
                    end else begin
                        env_d = env_sum[7:0];
                    end
                end
                S_SUSTAIN: begin
                    env_d = 8'd255;
                end
                S_RELEASE: begin
                    if (env_q <= 8'(RELEASE_STEP)) begin
                        env_d   = 8'd0;
                        state_d = S_IDLE;
                        phase_d = '0;
                    end else begin
                        env_d = env_q - 8'(RELEASE_STEP);
                    end
                end
                default: begin
                    env_d = env_q;
                end
            endcase
        end

        note_active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= S_IDLE;
            env_q         <= 8'd0;
            phase_q       <= '0;
            inc_q         <= '0;
            cur_note_q    <= 5'd0;
            sample_q      <= '0;
            sample_vld_q  <= 1'b0;
            note_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            env_q         <= env_d;
            phase_q       <= phase_d;
            inc_q         <= inc_d;
            cur_note_q    <= cur_note_d;
            sample_q      <= sample_d;
            sample_vld_q  <= sample_vld_d;
            note_active_q <= note_active_d;
        end
    end

    assign sample_out       = sample_q;
    assign sample_valid_out = sample_vld_q;
    assign note_active_out  = note_active_q;
    assign cur_note_out     = cur_note_q;

endmodule
